// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (IF) and LSU; one outstanding transaction, alternating priority on conflict.
// Latency: grant in cycle 0, mem_req_valid from cycle 1, response pulse the cycle after mem_rsp_valid.
// Backpressure: requesters wait while a transaction is in flight; mem request fields hold until mem_req_ready. Optional watchdog: ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int XLEN           = 64,
    parameter int MASK_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_rsp_valid,
    output logic [XLEN-1:0]   if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic              ls_wen,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic              ls_rsp_valid,
    output logic [XLEN-1:0]   ls_rsp_data,
    output logic              ls_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data
);

    if (MASK_W * 8 != XLEN || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_bus_arbiter: MASK_W must be XLEN/8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    // The current owner is always the last winner, so one flop serves both roles.
    logic              last_ls;
    logic [XLEN-1:0]   req_addr;
    logic              req_wen;
    logic [XLEN-1:0]   req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              if_rsp_q;
    logic              ls_rsp_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              grant_if;
    logic              grant_ls;
    logic              timeout;
    logic              rsp_done;

    // Grants are suppressed during reset so every ready output reads 0 while rst is low.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && rst) begin
            if (ls_req_valid && (!if_req_valid || !last_ls)) grant_ls = 1'b1;
            else if (if_req_valid)                           grant_if = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;

    assign timeout = (state == WAIT) && !mem_rsp_valid &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (rsp_done) rsp_err_q <= timeout;
        end
    end

    assign if_rsp_err = if_rsp_q & rsp_err_q;
    assign ls_rsp_err = ls_rsp_q & rsp_err_q;
`else
    assign timeout    = 1'b0;
    assign if_rsp_err = 1'b0;
    assign ls_rsp_err = 1'b0;
`endif

    assign rsp_done = (state == WAIT) && (mem_rsp_valid || timeout);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_if || grant_ls) state_nxt = REQ;
            REQ:     if (mem_req_ready)        state_nxt = WAIT;
            WAIT:    if (rsp_done)             state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_ls    <= 1'b0;
            req_addr   <= '0;
            req_wen    <= 1'b0;
            req_wdata  <= '0;
            req_wmask  <= '0;
            if_rsp_q   <= 1'b0;
            ls_rsp_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state    <= state_nxt;
            if_rsp_q <= rsp_done && !last_ls;
            ls_rsp_q <= rsp_done && last_ls;
            // Stores and watchdog expiries return zero data.
            if (rsp_done) rsp_data_q <= (req_wen || timeout) ? '0 : mem_rsp_data;
            if (grant_ls) begin
                last_ls   <= 1'b1;
                req_addr  <= ls_addr;
                req_wen   <= ls_wen;
                req_wdata <= ls_wdata;
                req_wmask <= ls_wmask;
            end else if (grant_if) begin
                last_ls   <= 1'b0;
                req_addr  <= if_addr;
                req_wen   <= 1'b0;
                req_wdata <= '0;
                req_wmask <= '0;
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = req_addr;
    assign mem_wen       = req_wen;
    assign mem_wdata     = req_wdata;
    assign mem_wmask     = req_wmask;
    assign if_rsp_valid  = if_rsp_q;
    assign ls_rsp_valid  = ls_rsp_q;
    assign if_rsp_data   = if_rsp_q ? rsp_data_q : '0;
    assign ls_rsp_data   = ls_rsp_q ? rsp_data_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of full transactions plus hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;
    localparam int XLEN   = 64;
    localparam int MASK_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [XLEN-1:0]   if_addr, if_rsp_data;
    logic              ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid, ls_rsp_err;
    logic [XLEN-1:0]   ls_addr, ls_wdata, ls_rsp_data;
    logic [MASK_W-1:0] ls_wmask;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rsp_data;
    logic [MASK_W-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.XLEN(XLEN), .MASK_W(MASK_W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        if_v;
        logic        ls_v;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        logic        exp_ls;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: grant, single-cycle accept, response, pulse, quiet cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        exp_addr = v.exp_ls ? v.addr + 64'h1000 : v.addr;
        exp_data = (v.exp_ls && v.wen) ? 64'h0 : v.rdata;
        if_req_valid = v.if_v;
        ls_req_valid = v.ls_v;
        if_addr      = v.addr;
        ls_addr      = v.addr + 64'h1000;
        ls_wen       = v.wen;
        ls_wdata     = v.wdata;
        ls_wmask     = v.wmask;
        @(negedge clk);
        chk($sformatf("v%0d if_req_ready", idx), if_req_ready, !v.exp_ls);
        chk($sformatf("v%0d ls_req_ready", idx), ls_req_ready, v.exp_ls);
        cyc();
        if_req_valid  = 1'b0;
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d mem_req_valid", idx), mem_req_valid, 1'b1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, exp_addr);
        chk($sformatf("v%0d mem_wen", idx), mem_wen, v.exp_ls & v.wen);
        chk($sformatf("v%0d mem_wmask", idx), mem_wmask, v.exp_ls ? v.wmask : 8'h0);
        if (v.exp_ls) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        cyc();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.rdata;
        @(negedge clk);
        chk($sformatf("v%0d early rsp", idx), {if_rsp_valid, ls_rsp_valid}, 2'b00);
        cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d if_rsp_valid", idx), if_rsp_valid, !v.exp_ls);
        chk($sformatf("v%0d ls_rsp_valid", idx), ls_rsp_valid, v.exp_ls);
        chk($sformatf("v%0d rsp_data", idx), v.exp_ls ? ls_rsp_data : if_rsp_data, exp_data);
        chk($sformatf("v%0d rsp_err", idx), {if_rsp_err, ls_rsp_err}, 2'b00);
        cyc();
        @(negedge clk);
        chk($sformatf("v%0d pulse end", idx), {if_rsp_valid, ls_rsp_valid}, 2'b00);
        cyc();
    endtask

    initial begin
        if_req_valid = 0; ls_req_valid = 0; if_addr = 0; ls_addr = 0;
        ls_wen = 0; ls_wdata = 0; ls_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;

        //          if ls wen addr                 wdata                 wmask  rdata                 exp_ls
        vecs[0] = '{1, 0, 0, 64'h0000_0000_8000_0000, 64'h0,                8'h00, 64'h0000_0000_0000_0013, 0};
        vecs[1] = '{1, 1, 0, 64'h0000_0000_8000_0100, 64'h0,                8'hFF, 64'h1111,                1};
        vecs[2] = '{1, 1, 0, 64'h0000_0000_8000_0200, 64'h0,                8'hFF, 64'h2222,                0};
        vecs[3] = '{1, 1, 0, 64'h0000_0000_8000_0300, 64'h0,                8'hFF, 64'h3333,                1};
        vecs[4] = '{0, 1, 1, 64'h0000_0000_8000_0400, 64'h0000_0000_CAFE_F00D, 8'hF0, 64'h4444,            1};
        vecs[5] = '{1, 0, 0, 64'h0000_0000_8000_0500, 64'h0,                8'h00, 64'h5555,                0};
        vecs[6] = '{1, 1, 1, 64'h0000_0000_8000_0600, 64'h0000_0000_1234_5678, 8'h3C, 64'h6666,            1};
        vecs[7] = '{1, 1, 1, 64'h0000_0000_8000_0700, 64'h9,                8'hFF, 64'h7777,                0};

        // Reset state, with both requesters asserting.
        if_req_valid = 1; ls_req_valid = 1;
        #12;
        chk("reset if_req_ready", if_req_ready, 1'b0);
        chk("reset ls_req_ready", ls_req_ready, 1'b0);
        chk("reset mem_req_valid", mem_req_valid, 1'b0);
        chk("reset mem_addr", mem_addr, 64'h0);
        chk("reset rsp_valid", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        if_req_valid = 0; ls_req_valid = 0;
        @(posedge clk); #1 rst = 1;
        cyc();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Store with memory stalling 4 cycles; IF waits and is granted in the pulse cycle.
        ls_req_valid = 1; ls_addr = 64'h8000_1000; ls_wen = 1;
        ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        @(negedge clk);
        chk("st ls_req_ready", ls_req_ready, 1'b1);
        cyc();
        ls_req_valid = 0; ls_wdata = '1; ls_wmask = 8'hFF;
        if_req_valid = 1; if_addr = 64'h8000_2000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("st stall%0d mem_req_valid", i), mem_req_valid, 1'b1);
            chk($sformatf("st stall%0d mem_addr", i), mem_addr, 64'h8000_1000);
            chk($sformatf("st stall%0d mem_wdata", i), mem_wdata, 64'hDEAD_BEEF);
            chk($sformatf("st stall%0d mem_wmask", i), mem_wmask, 8'h0F);
            chk($sformatf("st stall%0d mem_wen", i), mem_wen, 1'b1);
            chk($sformatf("st stall%0d if_req_ready", i), if_req_ready, 1'b0);
            cyc();
        end
        mem_req_ready = 1;
        @(negedge clk);
        chk("st accept mem_req_valid", mem_req_valid, 1'b1);
        cyc();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hBAD;
        @(negedge clk);
        chk("st wait if_req_ready", if_req_ready, 1'b0);
        cyc();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("st ls_rsp_valid", ls_rsp_valid, 1'b1);
        chk("st ls_rsp_data", ls_rsp_data, 64'h0);
        chk("st if_rsp_valid", if_rsp_valid, 1'b0);
        chk("regrant if_req_ready", if_req_ready, 1'b1);
        cyc();
        if_req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        chk("st pulse end", ls_rsp_valid, 1'b0);
        chk("regrant mem_addr", mem_addr, 64'h8000_2000);
        chk("regrant mem_wen", mem_wen, 1'b0);
        cyc();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hABCD;
        cyc();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("regrant if_rsp_valid", if_rsp_valid, 1'b1);
        chk("regrant if_rsp_data", if_rsp_data, 64'hABCD);
        chk("regrant ls_rsp_valid", ls_rsp_valid, 1'b0);
        cyc();

        // LSU load, then asynchronous reset mid-WAIT.
        ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h8000_3000;
        @(negedge clk);
        chk("rw ls_req_ready", ls_req_ready, 1'b1);
        cyc();
        ls_req_valid = 0; mem_req_ready = 1;
        cyc();
        mem_req_ready = 0; if_req_valid = 1; ls_req_valid = 1;
        #2 rst = 0;
        #1;
        chk("rw async mem_addr", mem_addr, 64'h0);
        chk("rw async if_req_ready", if_req_ready, 1'b0);
        chk("rw async ls_req_ready", ls_req_ready, 1'b0);
        mem_rsp_valid = 1; mem_rsp_data = 64'h99;
        cyc();
        if_req_valid = 0; ls_req_valid = 0;
        rst = 1;
        cyc();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("rw no pulse a", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        cyc();
        @(negedge clk);
        chk("rw no pulse b", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        cyc();
        if_req_valid = 1; ls_req_valid = 1; if_addr = 64'h8000_5000; ls_addr = 64'h8000_6000;
        @(negedge clk);
        chk("rw conflict ls_req_ready", ls_req_ready, 1'b1);
        chk("rw conflict if_req_ready", if_req_ready, 1'b0);
        cyc();
        if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        chk("rw conflict mem_addr", mem_addr, 64'h8000_6000);
        cyc();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'h77;
        cyc();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("rw ls_rsp_data", ls_rsp_data, 64'h77);
        cyc();

`ifdef ARB_TIMEOUT_EN
        // Silent memory: watchdog expires after 8 WAIT cycles.
        ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h8000_4000;
        @(negedge clk);
        chk("to ls_req_ready", ls_req_ready, 1'b1);
        cyc();
        ls_req_valid = 0; mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("to wait%0d ls_rsp_valid", i), ls_rsp_valid, 1'b0);
            cyc();
        end
        mem_rsp_valid = 1; mem_rsp_data = 64'h55;
        @(negedge clk);
        chk("to ls_rsp_valid", ls_rsp_valid, 1'b1);
        chk("to ls_rsp_err", ls_rsp_err, 1'b1);
        chk("to ls_rsp_data", ls_rsp_data, 64'h0);
        cyc();
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("to late rsp ignored", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        cyc();
        run_vec(vecs[5], 8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF requester) and the load/store unit (LSU requester) of the ysyx pipeline.
- Sits between fetch / MEM stage and the memory interface.
- Sequences one outstanding transaction at a time with valid/ready request and response handshakes.
- Resolves simultaneous requests fairly.

Parameters:
- XLEN, 64, address and data width in bits.
- MASK_W, 8, write byte-mask width (XLEN/8).
- TIMEOUT_CYCLES, 255, response watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  XLEN  fetch address.
- if_rsp_valid  out  1  fetch response pulse.
- if_rsp_data  out  XLEN  fetch read data.
- if_rsp_err  out  1  fetch response error.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted this cycle.
- ls_addr  in  XLEN  LSU address.
- ls_wen  in  1  1 = store, 0 = load.
- ls_wdata  in  XLEN  store data.
- ls_wmask  in  MASK_W  store byte mask.
- ls_rsp_valid  out  1  LSU response pulse.
- ls_rsp_data  out  XLEN  load data.
- ls_rsp_err  out  1  LSU response error.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  XLEN  memory address.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  XLEN  memory write data.
- mem_wmask  out  MASK_W  memory byte mask.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_data  in  XLEN  memory read data.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - All ready/valid/err outputs = 0; all data/addr/mask outputs = 0.
  - last_grant = IF.
  - Any in-flight transaction is abandoned; no response is ever issued for it.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Exactly one winner is selected combinationally. Its *_req_ready = 1 in that cycle, and its request fields are registered.
  - Next state is REQ, and grant_owner is recorded.
- Arbitration (both requesters valid in IDLE):
  - LSU wins unless last_grant = LSU, in which case IF wins (alternating on conflict).
  - A single valid requester always wins.
  - last_grant updates to the winner on every grant.
- REQ:
  - mem_req_valid = 1, with mem_addr/wen/wdata/wmask driven from the registered request.
  - Fields stay stable until mem_req_valid && mem_req_ready; then next state is WAIT.
  - For IF grants, mem_wen = 0 and mem_wmask = 0.
- WAIT:
  - On mem_rsp_valid, mem_rsp_data is registered and the state returns to IDLE.
  - Next cycle: the owner's *_rsp_valid = 1 for exactly one cycle, with *_rsp_data = captured data and *_rsp_err = 0.
  - Store responses carry data = 0.
- Pipelined re-grant: a new grant may occur in the same IDLE cycle that carries the previous response pulse.
- Memory protocol:
  - mem_rsp_valid is ignored outside WAIT.
  - Memory never responds in the cycle it accepts a request.
- Latency, best case (request accepted at cycle 0):
  - mem_req_valid at cycle 1.
  - mem_req_ready at cycle 1, mem_rsp_valid at cycle 2.
  - *_rsp_valid at cycle 3.
- Non-owner outputs: *_rsp_valid and *_req_ready of the non-owner are always 0.
- Requester rules: a requester must hold valid and fields stable until ready. A requester dropping valid before ready is legal; nothing is issued for it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no mem_rsp_valid, the state returns to IDLE and the owner gets a response pulse with err = 1, data = 0.
  - A late mem_rsp_valid arriving after that is ignored.
- When undefined: no counter; WAIT holds indefinitely; if_rsp_err and ls_rsp_err are tied to 0.

Test Plan:
- IF only, addr 0x80000000; memory ready immediately, responds with 0x00000013 next cycle -> if_req_ready at cycle 0; mem_req_valid at cycle 1 with mem_addr = 0x80000000, mem_wen = 0; if_rsp_valid pulse at cycle 3 with data 0x00000013, err = 0; ls_rsp_valid stays 0.
- IF and LSU valid together in 3 consecutive conflicts after reset -> grant order LSU, IF, LSU; each response routed only to its owner.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; mem_req_ready delayed 4 cycles -> mem fields stable all 4 cycles; ls_rsp_valid one pulse, data = 0.
- rst driven low mid-WAIT -> outputs 0 immediately (async); a subsequent mem_rsp_valid produces no response pulse; first grant after release goes to LSU on conflict.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8, memory never responds to a load -> ls_rsp_valid = 1 with ls_rsp_err = 1, data 0 after 8 WAIT cycles; the next request is granted normally.
